wfifo_rd_sequencer: RTL and testbench

//   Parametrised successor to the weight-FIFO output controller. Sequences the reads of a configurable

---
 rtl/wfifo_rd_sequencer.sv | 155 +++++++++++++++
 tb/tb_wfifo_rd_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wfifo_rd_sequencer.sv
// Weight-FIFO read sequencer: issues skewed per-column FIFO reads
// and delays the strobes to line up write enables with returning data.
module wfifo_rd_sequencer #(
  parameter int NUM_COL  = 16,
  parameter int MAX_ROWS = 16,
  parameter int READ_LAT = 2,
  parameter int SKEW     = 1,
  localparam int ROW_W  = $clog2(MAX_ROWS + 1),
  localparam int STEP_W =
    $clog2(MAX_ROWS + (NUM_COL - 1) * SKEW + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [ROW_W-1:0]   rows_cfg,
  input  logic [NUM_COL-1:0] col_mask,
  input  logic               hold,
  input  logic               abort,
  output logic [NUM_COL-1:0] fifo_rd_en,
  output logic [NUM_COL-1:0] w_wen,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [NUM_COL-1:0] mask_q, mask_d;
  logic               abort_q, abort_d;
  logic               cerr_q, cerr_d;
  logic               flush;
  logic               rows_ok;
  logic               drain_last;
  logic [STEP_W-1:0]  step_last;
  logic [NUM_COL-1:0] pipe_q [READ_LAT];

  assign rows_ok = (rows_cfg != '0) &&
                   (rows_cfg <= ROW_W'(MAX_ROWS));

  assign step_last = STEP_W'(rows_q)
                   + STEP_W'((NUM_COL - 1) * SKEW)
                   - STEP_W'(1);

  assign drain_last = (cnt_q == CNT_W'(READ_LAT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      rows_q  <= '0;
      mask_q  <= '0;
      abort_q <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      mask_q  <= mask_d;
      abort_q <= abort_d;
      cerr_q  <= cerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    mask_d  = mask_q;
    abort_d = 1'b0;
    cerr_d  = 1'b0;
    flush   = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      abort_d = 1'b1;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (rows_ok) begin
              state_d = ISSUE;
              step_d  = '0;
              rows_d  = rows_cfg;
              mask_d  = col_mask;
            end else begin
              cerr_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!hold) begin
            if (step_q == step_last) begin
              state_d = DRAIN;
              cnt_d   = '0;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_last) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Column c owns the step window [c*SKEW, c*SKEW+rows).
  always_comb begin
    fifo_rd_en = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      if (state_q == ISSUE && !hold && mask_q[c] &&
          step_q >= STEP_W'(c * SKEW) &&
          step_q < STEP_W'(c * SKEW) + STEP_W'(rows_q)) begin
        fifo_rd_en[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= fifo_rd_en;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign w_wen   = pipe_q[READ_LAT-1];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DRAIN) && drain_last;
  assign aborted = abort_q;
  assign cfg_err = cerr_q;

endmodule

// File: tb/tb_wfifo_rd_sequencer.sv
// Randomised and directed bench for wfifo_rd_sequencer against a
// step-count reference model of the read schedule.
module tb_wfifo_rd_sequencer;

  localparam int NC = 4;
  localparam int MR = 8;
  localparam int RL = 2;
  localparam int SK = 1;
  localparam int RW = $clog2(MR + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] rows_cfg = '0;
  logic [NC-1:0] col_mask = '0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic [NC-1:0] fifo_rd_en;
  logic [NC-1:0] w_wen;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          cfg_err;

  always #5 clk = ~clk;

  wfifo_rd_sequencer #(
    .NUM_COL (NC),
    .MAX_ROWS(MR),
    .READ_LAT(RL),
    .SKEW    (SK)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .rows_cfg  (rows_cfg),
    .col_mask  (col_mask),
    .hold      (hold),
    .abort     (abort),
    .fifo_rd_en(fifo_rd_en),
    .w_wen     (w_wen),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .cfg_err   (cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int done_at, ab_at, rd_cnt, ce_cnt, t0;

  bit            m_act, m_abp, m_cep;
  int            m_p, m_d, m_rows, m_s;
  logic [NC-1:0] m_mask;
  logic [NC-1:0] m_hist [RL];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_abp = 0; m_cep = 0;
    m_p = 0; m_d = 0; m_rows = 0; m_s = 0;
    m_mask = '0;
    for (int i = 0; i < RL; i++) m_hist[i] = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},   fifo_rd_en, 0);
    check({tag, "_wen"},  w_wen, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ab"},   aborted, 0);
    check({tag, "_ce"},   cfg_err, 0);
  endtask

  task automatic cyc(input bit s, input int r,
                     input logic [NC-1:0] m,
                     input bit h, input bit a);
    logic [NC-1:0] e_rd;
    bit            e_done;
    @(posedge clk);
    #1;
    start = s; rows_cfg = RW'(r); col_mask = m;
    hold = h; abort = a;
    e_rd = '0;
    if (m_act && m_p < m_s && !h) begin
      for (int c = 0; c < NC; c++) begin
        if (m_mask[c] && m_p >= c * SK && m_p < c * SK + m_rows)
          e_rd[c] = 1'b1;
      end
    end
    e_done = m_act && (m_p == m_s) && (m_d == RL - 1);
    @(negedge clk);
    check("rd_en",   fifo_rd_en, e_rd);
    check("w_wen",   w_wen, m_hist[RL-1]);
    check("busy",    busy, m_act);
    check("done",    done, e_done);
    check("aborted", aborted, m_abp);
    check("cfg_err", cfg_err, m_cep);
    if (done === 1'b1) done_at = cyc_n;
    if (aborted === 1'b1) ab_at = cyc_n;
    if (cfg_err === 1'b1) ce_cnt++;
    rd_cnt += $countones(fifo_rd_en);
    for (int i = RL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = e_rd;
    m_abp = 0;
    m_cep = 0;
    if (m_act && a) begin
      m_act = 0;
      m_abp = 1;
      for (int i = 0; i < RL; i++) m_hist[i] = '0;
    end else if (m_act) begin
      if (m_p < m_s) begin
        if (!h) m_p++;
      end else begin
        m_d++;
        if (m_d == RL) m_act = 0;
      end
    end else if (s && !a) begin
      if (r >= 1 && r <= MR) begin
        m_act = 1; m_p = 0; m_d = 0;
        m_rows = r; m_mask = m;
        m_s = r + (NC - 1) * SK;
      end else begin
        m_cep = 1;
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    t0 = cyc_n; done_at = -1;
    cyc(1, 3, 4'hF, 0, 0);
    idle(11);
    check("nom_done_cyc", done_at - t0, 8);

    t0 = cyc_n; done_at = -1; rd_cnt = 0;
    cyc(1, 3, 4'hF, 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle(10);
    check("hold_done_cyc", done_at - t0, 9);
    check("hold_rd_cnt", rd_cnt, 12);

    t0 = cyc_n; done_at = -1; ab_at = -1;
    cyc(1, 3, 4'hF, 0, 0);
    idle(3);
    cyc(0, 0, '0, 0, 1);
    idle(1);
    check("abort_cyc", ab_at - t0, 5);
    check("abort_no_done", done_at, -1);
    cyc(1, 3, 4'hF, 0, 0);
    idle(11);
    check("restart_done_cyc", done_at - t0, 14);

    ce_cnt = 0;
    cyc(1, 0, 4'hF, 0, 0);
    idle(1);
    cyc(1, 9, 4'hF, 0, 0);
    idle(1);
    check("cfg_err_cnt", ce_cnt, 2);

    t0 = cyc_n; done_at = -1;
    cyc(1, 3, 4'hF, 0, 0);
    idle(1);
    cyc(1, 8, 4'h5, 0, 0);
    idle(10);
    check("busy_start_done", done_at - t0, 8);

    cyc(1, 3, 4'hF, 0, 0);
    idle(2);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle(6);

    repeat (3000) begin
      cyc(($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 9)),
          NC'($urandom),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
